// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Drains the ps2_keyboard FIFO one byte at a time and decodes Set-2 scan codes.
//   The E0 (extended), F0 (break) and E1 (pause) prefixes are interpreted here.
//   Each real key byte produces a one-cycle key event that carries:
//     make/break/repeat flags, a fresh-press counter and an ASCII translation.
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   data        FIFO head byte, valid while ready=1
//   ready       FIFO non-empty
//   overflow    FIFO overflow flag from ps2_keyboard
//   nextdata_n  active-low pop strobe, low only in the POP state
//   key_valid   one-cycle event strobe (GAP state only)
//   key_code    scan code of the last event, prefixes stripped
//   key_ext     last event was E0-prefixed
//   key_release last event was a break
//   key_repeat  last event was a typematic make of the held key
//   ascii       ASCII of the last event (0 if unmapped, extended or break)
//   key_held    a key is currently held
//   key_count   number of fresh makes, wraps
//   ovf_seen    sticky overflow indicator
module ps2_scancode_decoder #(
   parameter int PAUSE_SKIP = 7,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       data,
   input  logic             ready,
   input  logic             overflow,
   output logic             nextdata_n,
   output logic             key_valid,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic             key_release,
   output logic             key_repeat,
   output logic [7:0]       ascii,
   output logic             key_held,
   output logic [CNT_W-1:0] key_count,
   output logic             ovf_seen
);

   localparam int SKIP_W = (PAUSE_SKIP > 1) ? $clog2(PAUSE_SKIP + 1) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, POP = 2'd1, GAP = 2'd2} state_t;

   state_t             state_r, state_s;
   logic [7:0]         byte_r, byte_s;
   logic [SKIP_W-1:0]  skip_cnt_r, skip_cnt_s;
   logic               ext_r, ext_s, brk_r, brk_s;
   logic               held_valid_r, held_valid_s;
   logic [8:0]         held_code_r, held_code_s;   // {ext, code}
   logic               lshift_r, lshift_s, rshift_r, rshift_s;
   logic               valid_r, valid_s;
   logic [7:0]         code_r, code_s;
   logic               kext_r, kext_s, krel_r, krel_s, krep_r, krep_s;
   logic [7:0]         ascii_r, ascii_s;
   logic [CNT_W-1:0]   count_r, count_s;
   logic               ovf_r;

   // Bytes that are keyboard protocol responses rather than key codes.
   function automatic logic is_ctrl(input logic [7:0] b);
      case (b)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ctrl = 1'b1;
         default:                                  is_ctrl = 1'b0;
      endcase
   endfunction

   // Lowercase / unshifted ASCII of a non-extended Set-2 code.
   function automatic logic [7:0] ascii_lc(input logic [7:0] b);
      case (b)
         8'h1C: ascii_lc = 8'h61;  8'h32: ascii_lc = 8'h62;  8'h21: ascii_lc = 8'h63;
         8'h23: ascii_lc = 8'h64;  8'h24: ascii_lc = 8'h65;  8'h2B: ascii_lc = 8'h66;
         8'h34: ascii_lc = 8'h67;  8'h33: ascii_lc = 8'h68;  8'h43: ascii_lc = 8'h69;
         8'h3B: ascii_lc = 8'h6A;  8'h42: ascii_lc = 8'h6B;  8'h4B: ascii_lc = 8'h6C;
         8'h3A: ascii_lc = 8'h6D;  8'h31: ascii_lc = 8'h6E;  8'h44: ascii_lc = 8'h6F;
         8'h4D: ascii_lc = 8'h70;  8'h15: ascii_lc = 8'h71;  8'h2D: ascii_lc = 8'h72;
         8'h1B: ascii_lc = 8'h73;  8'h2C: ascii_lc = 8'h74;  8'h3C: ascii_lc = 8'h75;
         8'h2A: ascii_lc = 8'h76;  8'h1D: ascii_lc = 8'h77;  8'h22: ascii_lc = 8'h78;
         8'h35: ascii_lc = 8'h79;  8'h1A: ascii_lc = 8'h7A;
         8'h45: ascii_lc = 8'h30;  8'h16: ascii_lc = 8'h31;  8'h1E: ascii_lc = 8'h32;
         8'h26: ascii_lc = 8'h33;  8'h25: ascii_lc = 8'h34;  8'h2E: ascii_lc = 8'h35;
         8'h36: ascii_lc = 8'h36;  8'h3D: ascii_lc = 8'h37;  8'h3E: ascii_lc = 8'h38;
         8'h46: ascii_lc = 8'h39;
         8'h29: ascii_lc = 8'h20;  8'h5A: ascii_lc = 8'h0D;
         default: ascii_lc = 8'h00;
      endcase
   endfunction

   // Apply shift to letters only; digits and others ignore it.
   function automatic logic [7:0] ascii_of(input logic [7:0] b, input logic shift);
      logic [7:0] lc;
      lc = ascii_lc(b);
      if (shift && (lc >= 8'h61) && (lc <= 8'h7A)) ascii_of = lc - 8'h20;
      else                                         ascii_of = lc;
   endfunction

   // Fetch FSM next state.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    if (ready) state_s = POP; else state_s = IDLE;
         POP:     state_s = GAP;
         GAP:     state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Byte capture and decode; decode results only change while in POP.
   always_comb begin
      byte_s       = byte_r;
      skip_cnt_s   = skip_cnt_r;
      ext_s        = ext_r;
      brk_s        = brk_r;
      held_valid_s = held_valid_r;
      held_code_s  = held_code_r;
      lshift_s     = lshift_r;
      rshift_s     = rshift_r;
      valid_s      = 1'b0;
      code_s       = code_r;
      kext_s       = kext_r;
      krel_s       = krel_r;
      krep_s       = krep_r;
      ascii_s      = ascii_r;
      count_s      = count_r;
      if ((state_r == IDLE) && ready) byte_s = data;
      else                            byte_s = byte_r;
      if (state_r == POP) begin
         if (skip_cnt_r != '0) begin
            skip_cnt_s = skip_cnt_r - SKIP_W'(1);
         end else if (byte_r == 8'hE1) begin
            skip_cnt_s = SKIP_W'(PAUSE_SKIP);
            ext_s      = 1'b0;
            brk_s      = 1'b0;
         end else if (byte_r == 8'hE0) begin
            ext_s = 1'b1;
         end else if (byte_r == 8'hF0) begin
            brk_s = 1'b1;
         end else if (is_ctrl(byte_r)) begin
            ext_s = 1'b0;
            brk_s = 1'b0;
         end else begin
            valid_s = 1'b1;
            code_s  = byte_r;
            kext_s  = ext_r;
            krel_s  = brk_r;
            ext_s   = 1'b0;
            brk_s   = 1'b0;
            if (!brk_r) begin
               // Make: same key as held means typematic repeat.
               if (held_valid_r && (held_code_r == {ext_r, byte_r})) begin
                  krep_s = 1'b1;
               end else begin
                  krep_s       = 1'b0;
                  held_valid_s = 1'b1;
                  held_code_s  = {ext_r, byte_r};
                  count_s      = count_r + CNT_W'(1);
               end
               if (ext_r) ascii_s = 8'h00;
               else       ascii_s = ascii_of(byte_r, lshift_r | rshift_r);
            end else begin
               krep_s  = 1'b0;
               ascii_s = 8'h00;
               if (held_valid_r && (held_code_r == {ext_r, byte_r})) held_valid_s = 1'b0;
               else                                                   held_valid_s = held_valid_r;
            end
            // Shift flags follow make/break of the non-extended shift keys.
            if (!ext_r) begin
               case (byte_r)
                  8'h12:   lshift_s = ~brk_r;
                  8'h59:   rshift_s = ~brk_r;
                  default: lshift_s = lshift_r;
               endcase
            end else begin
               lshift_s = lshift_r;
            end
         end
      end else begin
         valid_s = 1'b0;
      end
   end

   // State and decode registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         byte_r       <= 8'h00;
         skip_cnt_r   <= '0;
         ext_r        <= 1'b0;
         brk_r        <= 1'b0;
         held_valid_r <= 1'b0;
         held_code_r  <= 9'h000;
         lshift_r     <= 1'b0;
         rshift_r     <= 1'b0;
         valid_r      <= 1'b0;
         code_r       <= 8'h00;
         kext_r       <= 1'b0;
         krel_r       <= 1'b0;
         krep_r       <= 1'b0;
         ascii_r      <= 8'h00;
         count_r      <= '0;
      end else begin
         state_r      <= state_s;
         byte_r       <= byte_s;
         skip_cnt_r   <= skip_cnt_s;
         ext_r        <= ext_s;
         brk_r        <= brk_s;
         held_valid_r <= held_valid_s;
         held_code_r  <= held_code_s;
         lshift_r     <= lshift_s;
         rshift_r     <= rshift_s;
         valid_r      <= valid_s;
         code_r       <= code_s;
         kext_r       <= kext_s;
         krel_r       <= krel_s;
         krep_r       <= krep_s;
         ascii_r      <= ascii_s;
         count_r      <= count_s;
      end
   end

   // Sticky overflow flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst)           ovf_r <= 1'b0;
      else if (overflow) ovf_r <= 1'b1;
      else               ovf_r <= ovf_r;
   end

   assign nextdata_n  = (state_r == POP) ? 1'b0 : 1'b1;
   assign key_valid   = valid_r;
   assign key_code    = code_r;
   assign key_ext     = kext_r;
   assign key_release = krel_r;
   assign key_repeat  = krep_r;
   assign ascii       = ascii_r;
   assign key_held    = held_valid_r;
   assign key_count   = count_r;
   assign ovf_seen    = ovf_r;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: a byte table with expected events drives the FIFO
// handshake; expected events go into a scoreboard queue and are compared on key_valid.
module tb_ps2_scancode_decoder;

   logic       clk = 1'b0;
   logic       rst, ready, overflow;
   logic [7:0] data;
   logic       nextdata_n, key_valid, key_ext, key_release, key_repeat, key_held, ovf_seen;
   logic [7:0] key_code, ascii, key_count;

   ps2_scancode_decoder #(.PAUSE_SKIP(7), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .data(data), .ready(ready), .overflow(overflow),
      .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code),
      .key_ext(key_ext), .key_release(key_release), .key_repeat(key_repeat),
      .ascii(ascii), .key_held(key_held), .key_count(key_count), .ovf_seen(ovf_seen)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       evt;
      logic [7:0] code;
      logic       ext;
      logic       rel;
      logic       rep;
      logic [7:0] asc;
      logic       held;
      logic [7:0] cnt;
   } vec_t;

   localparam int N = 39;
   vec_t tbl [0:N-1];
   vec_t sb_q [$];

   int n_cmp = 0, n_err = 0;
   int bytes_sent = 0, evt_sent = 0;

   // Handshake monitor, sampled on the falling edge.
   int   pop_cnt = 0, kv_cnt = 0, nd_viol = 0, kv_viol = 0, gap_viol = 0, since_pop = 0;
   logic prev_nd = 1'b1;
   bit   any_pop = 1'b0;
   always @(negedge clk) begin
      since_pop = since_pop + 1;
      if (nextdata_n === 1'b0) begin
         pop_cnt = pop_cnt + 1;
         if (prev_nd === 1'b0) nd_viol = nd_viol + 1;
         if (any_pop && since_pop < 3) gap_viol = gap_viol + 1;
         any_pop   = 1'b1;
         since_pop = 0;
      end
      if (key_valid === 1'b1) begin
         kv_cnt = kv_cnt + 1;
         if (prev_nd !== 1'b0) kv_viol = kv_viol + 1;
      end
      prev_nd = nextdata_n;
   end

   function automatic vec_t mk(input logic [7:0] d, input logic evt, input logic [7:0] code,
                               input logic ext, input logic rel, input logic rep,
                               input logic [7:0] asc, input logic held, input logic [7:0] cnt);
      vec_t v;
      v.d = d; v.evt = evt; v.code = code; v.ext = ext; v.rel = rel; v.rep = rep;
      v.asc = asc; v.held = held; v.cnt = cnt;
      return v;
   endfunction

   function automatic vec_t nv(input logic [7:0] d);
      return mk(d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Present one byte on the FIFO head, wait for its pop, then check the GAP cycle.
   task automatic send(input vec_t v);
      bit   seen;
      vec_t e;
      data  = v.d;
      ready = 1'b1;
      if (v.evt) begin
         sb_q.push_back(v);
         evt_sent = evt_sent + 1;
      end
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         if (nextdata_n === 1'b0) seen = 1'b1;
      end
      bytes_sent = bytes_sent + 1;
      chk("pop_timeout", {31'd0, seen}, 32'd1);
      if (seen) begin
         @(negedge clk);
         chk("key_valid", {31'd0, key_valid}, {31'd0, v.evt});
         if (key_valid === 1'b1 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("key_code",    {24'd0, key_code},    {24'd0, e.code});
            chk("key_ext",     {31'd0, key_ext},     {31'd0, e.ext});
            chk("key_release", {31'd0, key_release}, {31'd0, e.rel});
            chk("key_repeat",  {31'd0, key_repeat},  {31'd0, e.rep});
            chk("ascii",       {24'd0, ascii},       {24'd0, e.asc});
            chk("key_held",    {31'd0, key_held},    {31'd0, e.held});
            chk("key_count",   {24'd0, key_count},   {24'd0, e.cnt});
         end else if (v.evt && sb_q.size() > 0) begin
            e = sb_q.pop_front();
         end
      end
   endtask

   logic [7:0] wc, wa;
   int         pops_before;

   initial begin
      // d, evt, code, ext, rel, rep, ascii, held, count
      tbl[0]  = mk(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 8'h61, 1'b1, 8'h01);
      tbl[1]  = nv(8'hF0);
      tbl[2]  = mk(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01);
      tbl[3]  = mk(8'h12, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02);
      tbl[4]  = mk(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 8'h41, 1'b1, 8'h03);
      tbl[5]  = mk(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1, 8'h03);
      tbl[6]  = nv(8'hF0);
      tbl[7]  = mk(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h03);
      tbl[8]  = nv(8'hF0);
      tbl[9]  = mk(8'h12, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h03);
      tbl[10] = nv(8'hE0);
      tbl[11] = mk(8'h75, 1'b1, 8'h75, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04);
      tbl[12] = nv(8'hE0);
      tbl[13] = nv(8'hF0);
      tbl[14] = mk(8'h75, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h04);
      tbl[15] = nv(8'hE1);
      tbl[16] = nv(8'h14);
      tbl[17] = nv(8'h77);
      tbl[18] = nv(8'hE1);
      tbl[19] = nv(8'hF0);
      tbl[20] = nv(8'h14);
      tbl[21] = nv(8'hF0);
      tbl[22] = nv(8'h77);
      tbl[23] = mk(8'h29, 1'b1, 8'h29, 1'b0, 1'b0, 1'b0, 8'h20, 1'b1, 8'h05);
      tbl[24] = nv(8'hFA);
      tbl[25] = nv(8'hE0);
      tbl[26] = nv(8'hFA);
      tbl[27] = mk(8'h16, 1'b1, 8'h16, 1'b0, 1'b0, 1'b0, 8'h31, 1'b1, 8'h06);
      tbl[28] = nv(8'hE0);
      tbl[29] = nv(8'hAA);
      tbl[30] = mk(8'h16, 1'b1, 8'h16, 1'b0, 1'b0, 1'b1, 8'h31, 1'b1, 8'h06);
      tbl[31] = mk(8'h59, 1'b1, 8'h59, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h07);
      tbl[32] = mk(8'h1A, 1'b1, 8'h1A, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 8'h08);
      tbl[33] = nv(8'hF0);
      tbl[34] = mk(8'h59, 1'b1, 8'h59, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h08);
      tbl[35] = mk(8'h1A, 1'b1, 8'h1A, 1'b0, 1'b0, 1'b1, 8'h7A, 1'b1, 8'h08);
      tbl[36] = mk(8'h5A, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h0D, 1'b1, 8'h09);
      tbl[37] = nv(8'hE0);
      tbl[38] = mk(8'h1C, 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h0A);

      // Reset state and no pop while the FIFO is empty.
      rst = 1'b1; ready = 1'b0; overflow = 1'b0; data = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_nextdata_n", {31'd0, nextdata_n}, 32'd1);
      chk("rst_key_valid",  {31'd0, key_valid},  32'd0);
      chk("rst_key_count",  {24'd0, key_count},  32'd0);
      chk("rst_ovf_seen",   {31'd0, ovf_seen},   32'd0);
      chk("rst_key_held",   {31'd0, key_held},   32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_no_pop", pop_cnt, 32'd0);

      // Table of byte sequences, fed back-to-back.
      for (int i = 0; i < N; i++) send(tbl[i]);

      // Fresh makes alternating two keys, long enough for key_count to wrap.
      for (int i = 0; i < 250; i++) begin
         wc = (i % 2 == 0) ? 8'h32 : 8'h1C;
         wa = (i % 2 == 0) ? 8'h62 : 8'h61;
         send(mk(wc, 1'b1, wc, 1'b0, 1'b0, 1'b0, wa, 1'b1, 8'(11 + i)));
      end
      ready = 1'b0;
      repeat (3) @(negedge clk);

      // Overflow pulse sets the sticky flag; decoding continues.
      overflow = 1'b1;
      @(negedge clk);
      overflow = 1'b0;
      repeat (2) @(negedge clk);
      chk("ovf_set", {31'd0, ovf_seen}, 32'd1);
      send(mk(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h61, 1'b1, 8'h04));
      ready = 1'b0;
      @(negedge clk);
      chk("ovf_sticky", {31'd0, ovf_seen}, 32'd1);

      // Reset asserted during POP: pop strobe released, no event.
      data = 8'h32; ready = 1'b1;
      pops_before = pop_cnt;
      for (int t = 0; t < 20 && nextdata_n !== 1'b0; t++) @(negedge clk);
      chk("rstpop_in_pop", {31'd0, nextdata_n}, 32'd0);
      bytes_sent = bytes_sent + 1;
      rst = 1'b1; ready = 1'b0;
      @(negedge clk);
      chk("rstpop_nextdata_n", {31'd0, nextdata_n}, 32'd1);
      chk("rstpop_key_valid",  {31'd0, key_valid},  32'd0);
      chk("rstpop_key_count",  {24'd0, key_count},  32'd0);
      chk("rstpop_ovf_seen",   {31'd0, ovf_seen},   32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rstpop_one_pop", pop_cnt - pops_before, 32'd1);

      // Global handshake accounting.
      chk("pops_vs_bytes",   pop_cnt, bytes_sent);
      chk("events_vs_table", kv_cnt,  evt_sent);
      chk("pop_width",       nd_viol,  32'd0);
      chk("valid_in_gap",    kv_viol,  32'd0);
      chk("pop_spacing",     gap_viol, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Consumer stage directly downstream of ps2_keyboard. Drains the keyboard FIFO over the ready/nextdata_n handshake and interprets Set-2 prefixes (E0 extended, F0 break, E1 pause). Emits one-cycle key events carrying make/break/repeat flags, a press counter and an ASCII translation, for display or CPU-side logic.

Parameters:
PAUSE_SKIP, 7, bytes discarded after an E1 prefix (remainder of the Pause sequence).
CNT_W, 8, width of key_count.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
data  input  8  FIFO head byte from ps2_keyboard; valid while ready=1.
ready  input  1  ps2_keyboard FIFO non-empty.
overflow  input  1  ps2_keyboard FIFO overflow flag.
nextdata_n  output  1  active-low pop strobe to ps2_keyboard.
key_valid  output  1  one-cycle event strobe.
key_code  output  8  scan code of the event, prefixes stripped.
key_ext  output  1  event was E0-prefixed.
key_release  output  1  event was a break (F0-prefixed).
key_repeat  output  1  make of the key already held (typematic).
ascii  output  8  ASCII of the event key; 0 if unmapped, extended or release.
key_held  output  1  a key is currently held.
key_count  output  CNT_W  count of fresh (non-repeat) makes; wraps.
ovf_seen  output  1  sticky: overflow was ever high since reset.

Behaviour:
- Reset: all outputs 0, except nextdata_n=1. FSM goes to IDLE. Prefix flags, skip counter, held code, shift flags and counter all clear. Reset mid-handshake drops the byte in flight; nextdata_n=1 from the next cycle.
- Fetch FSM (IDLE, POP, GAP):
  - IDLE: if ready=1, capture data into byte_r and go to POP.
  - POP: nextdata_n=0 for exactly this cycle (decoded from state). Decode byte_r; the event registers update at the exit edge. Go to GAP.
  - GAP: nextdata_n=1, key_valid driven as registered. Go to IDLE.
- Minimum 3 cycles per byte. key_valid is high only during GAP, exactly 2 cycles after the capture edge. nextdata_n is never low outside POP.
- Decode of byte_r in POP, in priority order:
  - skip_cnt≠0: decrement, drop byte.
  - E1: skip_cnt←PAUSE_SKIP, clear prefixes, no event.
  - E0: set ext flag, no event.
  - F0: set brk flag, no event.
  - 00, AA, EE, FA, FE, FF: control bytes. Drop and clear prefixes.
  - Any other byte: emit an event with key_code=byte_r, key_ext=ext, key_release=brk, then clear both flags.
- E0 and F0 may both precede a code (E0 F0 xx → ext=1, release=1).
- Held tracking (single key, {ext,code}):
  - Make matching held → key_repeat=1, count unchanged.
  - Make not matching held → held←new, key_held=1, key_count+1 (wraps 2^CNT_W-1→0).
  - Break matching held → key_held=0.
  - Break of another key → event only, held unchanged.
- Shift: non-ext 12 (left) and 59 (right) set/clear independent flags on make/break. Shift keys themselves produce ascii 0.
- ASCII mapping, non-ext makes only (repeats included):
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z. Lowercase; uppercase if either shift flag is set.
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9' (shift ignored).
  - Other keys: 29 → 0x20, 5A → 0x0D.
  - All else → 0.
- key_code, key_ext, key_release, key_repeat and ascii hold their values until the next event; only key_valid pulses.
- ovf_seen: set when overflow=1 on any edge, cleared only by rst. Decoding is unaffected.

Test Plan:
1. Reset: rst=1 for 2 cycles → nextdata_n=1, key_valid=0, key_count=0, ovf_seen=0. Release rst with ready=0 → no pop.
2. Bytes 1C, F0 1C → key_valid pulses twice:
   - make: code=1C, release=0, ascii=0x61, count=1, key_held=1.
   - break: release=1, ascii=0, key_held=0.
   - nextdata_n low for exactly 3 single cycles.
3. Bytes 12, 1C, 1C, F0 1C, F0 12:
   - ascii 0x41, then 0x41 with key_repeat=1.
   - Second 1C leaves count unchanged.
   - Events in order: 12 make, 1C make, 1C make, 1C break, 12 break.
4. Bytes E0 75, E0 F0 75 → code=75, ext=1, ascii=0 on both events, release 0 then 1. No event for the prefixes.
5. Pause sequence E1 14 77 E1 F0 14 F0 77, then 29 → no events for the first 8 bytes. One event code=29, ascii=0x20.
6. Back-to-back FIFO (ready held high for 4 bytes) → one pop per 3 cycles, no byte lost or duplicated. Pulse overflow=1 → ovf_seen=1 until rst. Assert rst during POP → nextdata_n=1 the next cycle and no key_valid.
